// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction-fetch front end. Generates the PC, issues one read at a time on
// the sram-like instruction port, buffers the returned word and hands
// {pc, instr, excepttype} to the ID stage with a valid/allowin handshake.
// Taken branches are applied after the delay slot has been delivered.
// Exception and ERET flushes redirect immediately.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req/wr/size/addr       sram-like read request (word reads only)
//   inst_addr_ok/data_ok/rdata  request accept, data return, read data
//   if_valid/pc/instr/except..  word presented to ID
//   id_allowin                  ID accepts the presented word this cycle
//   br_valid/br_target          taken branch/jump pulse from ID and target
//   exc_flush/exc_pc            exception or ERET redirect pulse and target
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_ADEL = 32'h00000004
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_excepttype,
    input  logic        id_allowin,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        brPend_q,   brPend_d;
    logic [31:0] brTgt_q,    brTgt_d;
    logic        cancel_q,   cancel_d;
    logic        ifValid_q,  ifValid_d;
    logic [31:0] ifInstr_q,  ifInstr_d;
    logic [31:0] ifExc_q,    ifExc_d;

    logic        launch;
    logic [31:0] launchPc;
    logic [31:0] nextPc;

    // The PC register doubles as the fetch address and as the PC of the
    // buffered word: it only advances at a handoff, so while a word is held
    // it still names that word.
    assign inst_req      = (state_q == REQ);
    assign inst_wr       = 1'b0;
    assign inst_size     = 2'b10;
    assign inst_addr     = pc_q;
    assign if_valid      = ifValid_q;
    assign if_pc         = pc_q;
    assign if_instr      = ifInstr_q;
    assign if_excepttype = ifExc_q;

    // Next-state logic. A flush wins over everything else. Any path that
    // starts fetching from a new PC goes through 'launch', which either
    // issues a bus request or, for a misaligned PC, presents an AdEL nop
    // straight away without touching the bus.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        brPend_d  = brPend_q;
        brTgt_d   = brTgt_q;
        cancel_d  = cancel_q;
        ifValid_d = ifValid_q;
        ifInstr_d = ifInstr_q;
        ifExc_d   = ifExc_q;
        launch    = 1'b0;
        launchPc  = pc_q;
        nextPc    = pc_q + 32'd4;

        if (exc_flush) begin
            pc_d      = exc_pc;
            brPend_d  = 1'b0;
            ifValid_d = 1'b0;
            case (state_q)
                REQ: begin
                    if (inst_addr_ok) begin
                        cancel_d = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        launch   = 1'b1;
                        launchPc = exc_pc;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        cancel_d = 1'b0;
                        launch   = 1'b1;
                        launchPc = exc_pc;
                    end else begin
                        cancel_d = 1'b1;
                    end
                end
                default: begin
                    launch   = 1'b1;
                    launchPc = exc_pc;
                end
            endcase
        end else begin
            if (br_valid) begin
                brPend_d = 1'b1;
                brTgt_d  = br_target;
            end
            case (state_q)
                IDLE: begin
                    launch = 1'b1;
                end
                REQ: begin
                    if (inst_addr_ok) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel_q) begin
                            cancel_d = 1'b0;
                            launch   = 1'b1;
                        end else begin
                            ifInstr_d = inst_rdata;
                            ifExc_d   = 32'd0;
                            ifValid_d = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                default: begin
                    if (ifValid_q && id_allowin) begin
                        // A branch seen in the same cycle as the delay-slot
                        // handoff redirects immediately.
                        if (br_valid) begin
                            nextPc = br_target;
                        end else if (brPend_q) begin
                            nextPc = brTgt_q;
                        end
                        pc_d      = nextPc;
                        brPend_d  = 1'b0;
                        ifValid_d = 1'b0;
                        launch    = 1'b1;
                        launchPc  = nextPc;
                    end
                end
            endcase
        end

        if (launch) begin
            if (launchPc[1:0] != 2'b00) begin
                state_d   = HOLD;
                ifValid_d = 1'b1;
                ifInstr_d = 32'd0;
                ifExc_d   = EXC_ADEL;
            end else begin
                state_d   = REQ;
                ifValid_d = 1'b0;
                ifExc_d   = 32'd0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            brPend_q  <= 1'b0;
            brTgt_q   <= 32'd0;
            cancel_q  <= 1'b0;
            ifValid_q <= 1'b0;
            ifInstr_q <= 32'd0;
            ifExc_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            brPend_q  <= brPend_d;
            brTgt_q   <= brTgt_d;
            cancel_q  <= cancel_d;
            ifValid_q <= ifValid_d;
            ifInstr_q <= ifInstr_d;
            ifExc_q   <= ifExc_d;
        end
    end

endmodule
